// File: rtl/proc_pkg.sv
// Shared definitions for the accumulator processor: opcodes, accumulator
// source selects, sequencer state encoding and error flag positions.
package proc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDR  = 4'h2;
    localparam logic [3:0] OP_STR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_FADD = 4'h8;
    localparam logic [3:0] OP_FMUL = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] SEL_IMM = 2'b00;
    localparam logic [1:0] SEL_RD  = 2'b01;
    localparam logic [1:0] SEL_RES = 2'b10;

    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_TIMEOUT = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_LOADI,
        S_RDREG,
        S_RDLOAD,
        S_WRREG,
        S_ASTART,
        S_AWAIT,
        S_AWB,
        S_HALT
    } state_t;

    // Opcodes that are executed by the external ALU/FPU
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_FMUL);
    endfunction

endpackage

// File: rtl/acc_sequencer_if.sv
// Bus bundle between the sequencer (master) and instruction memory,
// register file, ALU and accumulator (slave side).
interface acc_sequencer_if #(
    parameter int PC_W = 8
);
    logic            instr_req;
    logic            instr_valid;
    logic [15:0]     instr_data;
    logic [PC_W-1:0] pc;
    logic [3:0]      rf_raddr;
    logic [3:0]      rf_waddr;
    logic            rf_we;
    logic [3:0]      alu_op;
    logic            alu_start;
    logic            alu_done;
    logic            loadacc;
    logic [1:0]      selacc;
    logic [7:0]      immediate;

    modport master (
        output instr_req, pc, rf_raddr, rf_waddr, rf_we, alu_op, alu_start,
               loadacc, selacc, immediate,
        input  instr_valid, instr_data, alu_done
    );

    modport slave (
        input  instr_req, pc, rf_raddr, rf_waddr, rf_we, alu_op, alu_start,
               loadacc, selacc, immediate,
        output instr_valid, instr_data, alu_done
    );
endinterface

// File: rtl/acc_sequencer.sv
// Multi-cycle control FSM for the accumulator datapath: fetches and decodes
// 16-bit instructions and sequences accumulator, register-file and ALU control.
module acc_sequencer
    import proc_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int ALU_TIMEOUT = 64,
    parameter int OP_W        = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    acc_sequencer_if.master        bus,
    output logic                   busy,
    output logic                   halted,
    output logic [1:0]             err
);

    localparam int              CNT_W    = $clog2(ALU_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc_q;
    logic [OP_W-1:0]   op_q;
    logic [3:0]        rd_q;
    logic [7:0]        imm_q;
    logic [3:0]        raddr_q;
    logic [3:0]        waddr_q;
    logic [3:0]        alu_op_q;
    logic [1:0]        selacc_q;
    logic [1:0]        err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              instr_req, rf_we, alu_start, loadacc;
    logic              set_ill, set_tmo;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        instr_req = 1'b0;
        rf_we     = 1'b0;
        alu_start = 1'b0;
        loadacc   = 1'b0;
        set_ill   = 1'b0;
        set_tmo   = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                instr_req = 1'b1;
                if (bus.instr_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (op_q)
                    OP_NOP:  state_nxt = S_FETCH;
                    OP_LDI:  state_nxt = S_LOADI;
                    OP_LDR:  state_nxt = S_RDREG;
                    OP_STR:  state_nxt = S_WRREG;
                    OP_HALT: state_nxt = S_HALT;
                    default: begin
                        if (is_alu_op(op_q)) begin
                            state_nxt = S_ASTART;
                        end else begin
                            set_ill   = 1'b1;
                            state_nxt = S_HALT;
                        end
                    end
                endcase
            end
            S_LOADI:  begin loadacc = 1'b1; state_nxt = S_FETCH; end
            S_RDREG:  state_nxt = S_RDLOAD;
            S_RDLOAD: begin loadacc = 1'b1; state_nxt = S_FETCH; end
            S_WRREG:  begin rf_we = 1'b1; state_nxt = S_FETCH; end
            S_ASTART: begin alu_start = 1'b1; state_nxt = S_AWAIT; end
            // Done is only honoured here, so a done coincident with start is dropped
            S_AWAIT: begin
                if (bus.alu_done) begin
                    state_nxt = S_AWB;
                end else if (cnt_q == CNT_LAST) begin
                    set_tmo   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_AWB:    begin loadacc = 1'b1; state_nxt = S_FETCH; end
            S_HALT:   if (start) state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Operand/address registers change on entry to the state that uses them
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q     <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            alu_op_q <= '0;
            selacc_q <= SEL_IMM;
            err_q    <= '0;
            cnt_q    <= '0;
        end else begin
            if (state == S_FETCH && bus.instr_valid) begin
                op_q  <= bus.instr_data[15 -: OP_W];
                rd_q  <= bus.instr_data[11:8];
                imm_q <= bus.instr_data[7:0];
                pc_q  <= pc_q + 1'b1;
            end
            if (state == S_DECODE) begin
                case (state_nxt)
                    S_LOADI:  selacc_q <= SEL_IMM;
                    S_RDREG:  raddr_q  <= rd_q;
                    S_WRREG:  waddr_q  <= rd_q;
                    S_ASTART: begin
                        raddr_q  <= rd_q;
                        alu_op_q <= op_q;
                    end
                    default: ;
                endcase
            end
            if (state == S_RDREG) selacc_q <= SEL_RD;
            if (state == S_AWAIT && bus.alu_done) selacc_q <= SEL_RES;
            if (state == S_ASTART) begin
                cnt_q <= '0;
            end else if (state == S_AWAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (set_ill) err_q[ERR_ILLEGAL] <= 1'b1;
            if (set_tmo) err_q[ERR_TIMEOUT] <= 1'b1;
        end
    end

    assign bus.instr_req = instr_req;
    assign bus.pc        = pc_q;
    assign bus.rf_raddr  = raddr_q;
    assign bus.rf_waddr  = waddr_q;
    assign bus.rf_we     = rf_we;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_start = alu_start;
    assign bus.loadacc   = loadacc;
    assign bus.selacc    = selacc_q;
    assign bus.immediate = imm_q;

    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);
    assign err    = err_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: fetch handshake, LDI/LDR/STR/ALU timing,
// ALU timeout, illegal opcode, pc wrap and reset during an ALU wait.
module tb_acc_sequencer;
    import proc_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       busy;
    logic       halted;
    logic [1:0] err;

    int n_checks = 0;
    int n_errors = 0;
    int n_load   = 0;
    int n_we     = 0;
    int n_astart = 0;

    acc_sequencer_if #(.PC_W(8)) bus ();

    acc_sequencer #(.PC_W(8), .ALU_TIMEOUT(64), .OP_W(4)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .bus    (bus.master),
        .busy   (busy),
        .halted (halted),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.loadacc)   n_load   <= n_load + 1;
        if (bus.rf_we)     n_we     <= n_we + 1;
        if (bus.alu_start) n_astart <= n_astart + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_fetch(input logic [15:0] ins, input int delay);
        int n;
        n = 0;
        while (!bus.instr_req && n < 20) begin
            tick();
            n++;
        end
        if (!bus.instr_req) chk("fetch_req_timeout", 32'(bus.instr_req), 32'd1);
        repeat (delay) tick();
        bus.instr_valid = 1'b1;
        bus.instr_data  = ins;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, 32'({busy, halted, bus.instr_req, err}), 32'd0);
        chk({tag, "_strb"}, 32'({bus.rf_we, bus.alu_start, bus.loadacc}), 32'd0);
        chk({tag, "_regs"}, 32'({bus.selacc, bus.alu_op, bus.immediate, bus.rf_raddr, bus.rf_waddr}), 32'd0);
        chk({tag, "_pc"}, 32'(bus.pc), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int req_cnt;
        int s_load, s_we, s_astart;

        rstn = 1'b0;
        start = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 16'h0000;
        bus.alu_done    = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        chk_reset("reset");

        // LDI 0x5A, instruction valid after 3 wait cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.instr_req) req_cnt++;
            tick();
        end
        if (bus.instr_req) req_cnt++;
        chk("ldi_pc_before", 32'(bus.pc), 32'd0);
        bus.instr_valid = 1'b1;
        bus.instr_data  = 16'h105A;
        tick();
        bus.instr_valid = 1'b0;
        chk("ldi_req_cycles", 32'(req_cnt), 32'd4);
        chk("ldi_req_drop", 32'(bus.instr_req), 32'd0);
        chk("ldi_pc_after", 32'(bus.pc), 32'd1);
        chk("ldi_no_early_load", 32'(bus.loadacc), 32'd0);
        tick();
        chk("ldi_load", 32'({bus.loadacc, bus.selacc}), 32'({1'b1, SEL_IMM}));
        chk("ldi_imm", 32'(bus.immediate), 32'h5A);
        tick();
        chk("ldi_pulse_end", 32'({bus.loadacc, bus.instr_req}), 32'b01);

        // LDR r3 then ADD r2, done 5 cycles after alu_start
        do_fetch(16'h2300, 0);
        tick();
        chk("ldr_raddr", 32'({bus.rf_raddr, bus.loadacc}), 32'({4'h3, 1'b0}));
        tick();
        chk("ldr_load", 32'({bus.loadacc, bus.selacc}), 32'({1'b1, SEL_RD}));
        tick();
        s_astart = n_astart;
        do_fetch(16'h4200, 0);
        tick();
        chk("add_start", 32'({bus.alu_start, bus.alu_op, bus.rf_raddr}), 32'({1'b1, 4'h4, 4'h2}));
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        chk("add_early_done_ignored", 32'({busy, bus.loadacc, bus.alu_start}), 32'b100);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("add_wait_noload", 32'({busy, bus.loadacc}), 32'b10);
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        chk("add_writeback", 32'({bus.loadacc, bus.selacc}), 32'({1'b1, SEL_RES}));
        chk("add_op_held", 32'(bus.alu_op), 32'd4);
        tick();
        chk("add_after_wb", 32'({bus.loadacc, bus.instr_req, bus.selacc}), 32'({1'b0, 1'b1, SEL_RES}));
        chk("add_start_count", 32'(n_astart - s_astart), 32'd1);

        // STR r7
        do_fetch(16'h3700, 0);
        tick();
        chk("str_write", 32'({bus.rf_we, bus.rf_waddr}), 32'({1'b1, 4'h7}));
        tick();
        chk("str_pulse_end", 32'({bus.rf_we, bus.instr_req}), 32'b01);
        chk("str_pc", 32'(bus.pc), 32'd4);

        // FADD with no done: timeout after 64 AWAIT cycles
        do_fetch(16'h8100, 0);
        tick();
        chk("fadd_start", 32'({bus.alu_start, bus.alu_op}), 32'({1'b1, 4'h8}));
        repeat (64) tick();
        chk("fadd_last_wait", 32'({busy, halted, err}), 32'({1'b1, 1'b0, 2'b00}));
        tick();
        chk("fadd_timeout", 32'({busy, halted, err}), 32'({1'b0, 1'b1, 2'b10}));
        chk("fadd_halt_quiet", 32'({bus.instr_req, bus.loadacc, bus.rf_we, bus.alu_start}), 32'd0);
        tick();
        chk("fadd_pc_frozen", 32'(bus.pc), 32'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fadd_resume", 32'({bus.instr_req, bus.pc}), 32'({1'b1, 8'h05}));
        chk("fadd_err_sticky", 32'(err), 32'b10);

        // Illegal opcode 0xB
        s_load = n_load;
        s_we = n_we;
        s_astart = n_astart;
        do_fetch(16'hB123, 0);
        tick();
        chk("illegal_halt", 32'({halted, busy, err}), 32'({1'b1, 1'b0, 2'b11}));
        repeat (3) tick();
        chk("illegal_no_strobes", 32'((n_load - s_load) + (n_we - s_we) + (n_astart - s_astart)), 32'd0);
        chk("illegal_pc", 32'(bus.pc), 32'd6);

        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk_reset("reset2");

        // pc wrap: 255 NOPs, then a NOP fetched at 0xFF
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 255; i++) begin
            do_fetch(16'h0000, 0);
            tick();
            if (i == 0) chk("nop_two_cycles", 32'({bus.instr_req, bus.pc}), 32'({1'b1, 8'h01}));
        end
        chk("wrap_pc_ff", 32'(bus.pc), 32'hFF);
        do_fetch(16'h0000, 0);
        chk("wrap_pc_zero", 32'(bus.pc), 32'd0);
        tick();
        chk("wrap_next_fetch", 32'({bus.instr_req, bus.pc}), 32'({1'b1, 8'h00}));

        // Reset in the middle of an ALU wait, late done must be ignored
        do_fetch(16'h5412, 0);
        tick();
        chk("sub_start", 32'({bus.alu_start, bus.alu_op, bus.immediate}), 32'({1'b1, 4'h5, 8'h12}));
        tick();
        tick();
        s_load = n_load;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk_reset("reset_await");
        tick();
        tick();
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        repeat (3) tick();
        chk("post_reset_idle", 32'({busy, halted, bus.instr_req, bus.selacc}), 32'd0);
        chk("post_reset_no_load", 32'(n_load - s_load), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
